// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared types and constants for the exception address sequencer
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VEC  = 2'd1,
        LOAD = 2'd2,
        RET  = 2'd3
    } excStateT;

    localparam int CAUSE_NOOP = 0;
    localparam int CAUSE_OVFL = 1;
    localparam int CAUSE_DIV0 = 2;

    localparam int DEFAULT_VEC_BASE = 253;
    localparam int EPC_OFFSET       = 4;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - lowest-index-wins priority encoder with any-valid flag
module exc_prio_enc #(
    parameter int N  = 3,
    parameter int CW = 2
) (
    input  logic [N-1:0]  req,
    output logic [CW-1:0] code,
    output logic          valid
);

    // Scan from the top down so the lowest set index is written last and wins.
    always_comb begin
        code = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) code = CW'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/exc_addr_seq.sv
// rtl/exc_addr_seq.sv - memory address source with prioritised exception-vector fetch
module exc_addr_seq
    import exc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_CAUSES = 3,
    parameter int VEC_BASE   = DEFAULT_VEC_BASE,
    parameter int MEM_LAT    = 1,
    localparam int CW        = (NUM_CAUSES > 1) ? $clog2(NUM_CAUSES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  addr_sel,
    input  logic [WIDTH-1:0]      in_pc,
    input  logic [WIDTH-1:0]      in_aluOut,
    input  logic [NUM_CAUSES-1:0] cause_req,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic [WIDTH-1:0]      out_addr,
    output logic                  exc_busy,
    output logic                  epc_we,
    output logic [WIDTH-1:0]      epc_out,
    output logic [CW-1:0]         cause_code,
    output logic                  pc_load,
    output logic [WIDTH-1:0]      pc_next
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WIDTH-1:0] VEC_BASE_W = WIDTH'(VEC_BASE);

    excStateT              state;
    logic [NUM_CAUSES-1:0] pending;
    logic [NUM_CAUSES-1:0] reqAll;
    logic [NUM_CAUSES-1:0] selMask;
    logic [CW-1:0]         selCode;
    logic                  anyReq;
    logic [CNT_W-1:0]      latCnt;
    logic                  unusedRdata;

    assign reqAll      = pending | cause_req;
    assign selMask     = NUM_CAUSES'(1) << selCode;
    assign exc_busy    = (state != IDLE);
    assign unusedRdata = ^mem_rdata[WIDTH-1:8];

    exc_prio_enc #(
        .N  (NUM_CAUSES),
        .CW (CW)
    ) uPrioEnc (
        .req   (reqAll),
        .code  (selCode),
        .valid (anyReq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            latCnt     <= '0;
            out_addr   <= '0;
            epc_we     <= 1'b0;
            epc_out    <= '0;
            cause_code <= '0;
            pc_load    <= 1'b0;
            pc_next    <= '0;
        end else begin
            // New requests always merge into the pending mask; the serviced bit is cleared below.
            pending <= reqAll;
            case (state)
                IDLE: begin
                    out_addr <= addr_sel ? in_aluOut : in_pc;
                    if (anyReq) begin
                        state      <= VEC;
                        pending    <= reqAll & ~selMask;
                        cause_code <= selCode;
                        out_addr   <= VEC_BASE_W + WIDTH'(selCode);
                        epc_out    <= in_pc - WIDTH'(EPC_OFFSET);
                        epc_we     <= 1'b1;
                        latCnt     <= CNT_W'(MEM_LAT - 1);
                    end
                end
                VEC: begin
                    epc_we <= 1'b0;
                    if (latCnt == '0) state  <= LOAD;
                    else              latCnt <= latCnt - 1'b1;
                end
                LOAD: begin
                    pc_next <= WIDTH'(mem_rdata[7:0]);
                    pc_load <= 1'b1;
                    state   <= RET;
                end
                RET: begin
                    pc_load <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_addr_seq.sv
// tb/tb_exc_addr_seq.sv - scoreboard bench for exc_addr_seq
module tb_exc_addr_seq;
    import exc_pkg::*;

    typedef struct {
        bit          isPc;
        logic [31:0] val;
        logic [1:0]  code;
        logic [31:0] addr;
    } evT;

    logic        clk = 1'b0;
    logic        reset, reset3;
    logic        addrSel;
    logic [31:0] inPc, inAlu, memRdata;
    logic [2:0]  causeReq, causeReq3;

    logic [31:0] outAddr, epcOut, pcNext;
    logic        busy, epcWe, pcLoad;
    logic [1:0]  causeCode;
    logic [31:0] outAddr3, epcOut3, pcNext3;
    logic        busy3, epcWe3, pcLoad3;
    logic [1:0]  causeCode3;

    evT q[$];
    evT q3[$];
    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    exc_addr_seq #(.WIDTH(32), .NUM_CAUSES(3), .VEC_BASE(253), .MEM_LAT(1)) dut (
        .clk(clk), .reset(reset), .addr_sel(addrSel), .in_pc(inPc), .in_aluOut(inAlu),
        .cause_req(causeReq), .mem_rdata(memRdata), .out_addr(outAddr), .exc_busy(busy),
        .epc_we(epcWe), .epc_out(epcOut), .cause_code(causeCode), .pc_load(pcLoad),
        .pc_next(pcNext)
    );

    exc_addr_seq #(.WIDTH(32), .NUM_CAUSES(3), .VEC_BASE(253), .MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset3), .addr_sel(addrSel), .in_pc(inPc), .in_aluOut(inAlu),
        .cause_req(causeReq3), .mem_rdata(memRdata), .out_addr(outAddr3), .exc_busy(busy3),
        .epc_we(epcWe3), .epc_out(epcOut3), .cause_code(causeCode3), .pc_load(pcLoad3),
        .pc_next(pcNext3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushSeq(input logic [1:0] code, input logic [31:0] epc, input logic [7:0] data);
        evT e;
        e.isPc = 1'b0; e.val = epc; e.code = code; e.addr = 32'd253 + 32'(code);
        q.push_back(e);
        e.isPc = 1'b1; e.val = {24'd0, data};
        q.push_back(e);
    endtask

    // Monitor: each strobe from a DUT consumes exactly one expected event.
    always @(negedge clk) begin
        evT e;
        if (epcWe || pcLoad) begin
            if (q.size() == 0) begin
                check("dut unexpected strobe", {30'd0, epcWe, pcLoad}, 32'd0);
            end else begin
                e = q.pop_front();
                check("dut strobe kind", {31'd0, pcLoad}, {31'd0, e.isPc});
                check("dut out_addr at strobe", outAddr, e.addr);
                if (e.isPc) begin
                    check("dut pc_next", pcNext, e.val);
                end else begin
                    check("dut epc_out", epcOut, e.val);
                    check("dut cause_code", {30'd0, causeCode}, {30'd0, e.code});
                end
            end
        end
        if (epcWe3 || pcLoad3) begin
            if (q3.size() == 0) begin
                check("dut3 unexpected strobe", {30'd0, epcWe3, pcLoad3}, 32'd0);
            end else begin
                e = q3.pop_front();
                check("dut3 strobe kind", {31'd0, pcLoad3}, {31'd0, e.isPc});
                check("dut3 epc_out", epcOut3, e.val);
                check("dut3 out_addr at strobe", outAddr3, e.addr);
            end
        end
    end

    initial begin
        evT e3;
        reset = 1'b1; reset3 = 1'b1; addrSel = 1'b0;
        inPc = 32'h0; inAlu = 32'h0; memRdata = 32'h0;
        causeReq = 3'b000; causeReq3 = 3'b000;
        tick(2);
        check("reset out_addr", outAddr, 32'h0);
        check("reset exc_busy", {31'd0, busy}, 32'd0);
        check("reset epc_out", epcOut, 32'h0);
        check("reset pc_next", pcNext, 32'h0);
        check("reset strobes", {30'd0, epcWe, pcLoad}, 32'd0);
        reset = 1'b0; reset3 = 1'b0;

        // Normal mode
        addrSel = 1'b0; inPc = 32'h40;
        tick();
        check("normal pc", outAddr, 32'h40);
        addrSel = 1'b1; inAlu = 32'h1234;
        tick();
        check("normal alu", outAddr, 32'h1234);
        check("normal busy", {31'd0, busy}, 32'd0);
        addrSel = 1'b0;

        // Overflow, single cause
        inPc = 32'h108; causeReq = 3'b010;
        pushSeq(2'd1, 32'h104, 8'hA7);
        tick();
        causeReq = 3'b000; memRdata = 32'h12345AA7;
        check("ovfl busy t+1", {31'd0, busy}, 32'd1);
        check("ovfl epc_we t+1", {31'd0, epcWe}, 32'd1);
        tick(2);
        check("ovfl pc_load t+3", {31'd0, pcLoad}, 32'd1);
        tick();
        check("ovfl idle t+4", {31'd0, busy}, 32'd0);

        // Simultaneous causes 0 and 2
        inPc = 32'h200; memRdata = 32'h000000C3; causeReq = 3'b101;
        pushSeq(2'd0, 32'h1FC, 8'hC3);
        pushSeq(2'd2, 32'h1FC, 8'hC3);
        tick();
        causeReq = 3'b000;
        tick(3);
        check("simul gap idle", {31'd0, busy}, 32'd0);
        tick();
        check("simul second vec", outAddr, 32'hFF);
        tick(5);

        // Cause 2 arrives during LOAD of a cause-1 sequence
        inPc = 32'h300; memRdata = 32'h0000005E; causeReq = 3'b010;
        pushSeq(2'd1, 32'h2FC, 8'h5E);
        pushSeq(2'd2, 32'h2FC, 8'h5E);
        tick();
        causeReq = 3'b000;
        tick();
        check("busy-latch in LOAD", {31'd0, busy}, 32'd1);
        causeReq = 3'b100;
        tick();
        causeReq = 3'b000;
        tick();
        check("busy-latch idle gap", {31'd0, busy}, 32'd0);
        tick();
        check("busy-latch vec epc_we", {31'd0, epcWe}, 32'd1);
        check("busy-latch vec addr", outAddr, 32'hFF);
        tick(5);

        // EPC wrap
        inPc = 32'h2; memRdata = 32'h0000001F; causeReq = 3'b001;
        pushSeq(2'd0, 32'hFFFFFFFE, 8'h1F);
        tick();
        causeReq = 3'b000;
        tick(5);

        // Reset mid-VEC on the MEM_LAT=3 instance, with cause 1 left pending
        inPc = 32'h400; causeReq3 = 3'b011;
        e3.isPc = 1'b0; e3.val = 32'h3FC; e3.code = 2'd0; e3.addr = 32'hFD;
        q3.push_back(e3);
        tick();
        causeReq3 = 3'b000;
        check("dut3 busy in VEC", {31'd0, busy3}, 32'd1);
        tick();
        reset3 = 1'b1;
        tick();
        reset3 = 1'b0;
        check("dut3 reset out_addr", outAddr3, 32'h0);
        check("dut3 reset busy", {31'd0, busy3}, 32'd0);
        check("dut3 reset epc_out", epcOut3, 32'h0);
        check("dut3 reset cause_code", {30'd0, causeCode3}, 32'd0);
        check("dut3 reset strobes", {30'd0, epcWe3, pcLoad3}, 32'd0);
        tick(10);
        check("dut3 stays idle", {31'd0, busy3}, 32'd0);

        check("dut events left", q.size(), 32'd0);
        check("dut3 events left", q3.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/exc_addr_seq.md
# exc_addr_seq

Parametrised memory-address source and exception-vector sequencer for the multicycle CPU datapath. In normal operation it registers the memory address, selected from PC or ALUOut. When an exception cause is raised, it takes over the memory port: it writes EPC, issues a read at the cause's vector byte address, waits out the memory latency, and hands the loaded byte back as the new PC. Multiple causes are queued by fixed priority, so simultaneous or overlapping exceptions are never lost.

## Interface
- `WIDTH`, 32: address/data width.
- `NUM_CAUSES`, 3: exception cause count; bit 0 = no-op/opcode, 1 = overflow, 2 = div-by-zero.
- `VEC_BASE`, 253: byte address of the cause-0 vector; cause k uses `VEC_BASE + k`.
- `MEM_LAT`, 1 (≥1): cycles from address presented to `mem_rdata` valid.
- `CW`: derived, `max(1, clog2(NUM_CAUSES))`.

Ports:
- `clk`  in  1  clock. One clock domain. Reset is synchronous and active-high.
- `reset`  in  1  synchronous active-high reset.
- `addr_sel`  in  1  normal-mode source: 0 = `in_pc`, 1 = `in_aluOut`.
- `in_pc`  in  WIDTH  current (already incremented) PC.
- `in_aluOut`  in  WIDTH  ALUOut register.
- `cause_req`  in  NUM_CAUSES  one-cycle cause pulses; multiple bits allowed.
- `mem_rdata`  in  WIDTH  memory read data; only bits [7:0] are used.
- `out_addr`  out  WIDTH  registered memory address.
- `exc_busy`  out  1  high while the sequencer owns the memory port.
- `epc_we`  out  1  one-cycle EPC write strobe.
- `epc_out`  out  WIDTH  EPC value.
- `cause_code`  out  CW  code of the cause being serviced.
- `pc_load`  out  1  one-cycle PC write strobe.
- `pc_next`  out  WIDTH  new PC, zero-extended vector byte.

## Operation
- States:
  - IDLE: `out_addr <= addr_sel ? in_aluOut : in_pc` every cycle.
  - VEC: `out_addr` = vector; held for MEM_LAT cycles via a down-counter.
  - LOAD: captures `mem_rdata[7:0]`.
  - RET: `pc_load` = 1.
- Pending mask P (NUM_CAUSES bits): `P <= P | cause_req` every cycle. The bit being serviced is cleared on entry to VEC. A repeated request for an already-pending cause merges into that bit; it is not counted twice.
- IDLE → VEC when `(P | cause_req) != 0`. Selected code = lowest set index of `P | cause_req`; lower index has higher priority.
- On entry to VEC:
  - `cause_code` = selected code.
  - `out_addr` = `VEC_BASE + code`.
  - `epc_out` = `in_pc - 4`, sampled in the IDLE decision cycle, mod 2^WIDTH.
  - `epc_we` = 1 for exactly one cycle.
- VEC → LOAD after MEM_LAT cycles. LOAD → RET unconditionally. RET → IDLE unconditionally.
- Remaining pending causes are serviced only after one IDLE cycle. That IDLE cycle is the decision cycle, and `out_addr` reloads from the normal source in it.
- `exc_busy` = state ≠ IDLE.
- `out_addr` holds the vector through LOAD and RET.
- `cause_code`, `epc_out` and `pc_next` hold their values until overwritten.
- Reset values: every output 0, state IDLE, P = 0, counter 0.
- `reset` asserted in any state, including mid-sequence: the next cycle is the reset state. P is cleared and no `pc_load` or `epc_we` is emitted.

## Timing
- Normal mode: `out_addr` has 1-cycle latency from `addr_sel`/`in_pc`/`in_aluOut`.
- For a request first visible in IDLE cycle t:
  - t+1 … t+MEM_LAT: VEC, `epc_we` high at t+1 only.
  - t+MEM_LAT+1: LOAD.
  - t+MEM_LAT+2: RET, `pc_load` = 1, `pc_next` valid.
  - t+MEM_LAT+3: IDLE.
- `exc_busy` is high from t+1 through t+MEM_LAT+2.
- Back-to-back pending causes: the next VEC begins at t+MEM_LAT+4.
- Requests arriving while busy, or in the same cycle as the accepted request, are only latched into P.

## Structure
- Shared package `exc_pkg`:
  - state enum {IDLE, VEC, LOAD, RET};
  - cause index constants (CAUSE_NOOP = 0, CAUSE_OVFL = 1, CAUSE_DIV0 = 2);
  - default VEC_BASE;
  - EPC_OFFSET = 4.
- Sub-module `exc_prio_enc`: parametrised lowest-index priority encoder with CW-bit code and any-valid flag.

## Test plan
- Normal mode, after reset: `addr_sel=0`, `in_pc=0x40` → `out_addr=0x40` next cycle. Then `addr_sel=1`, `in_aluOut=0x1234` → `0x1234` next cycle. `exc_busy` stays 0 throughout.
- Overflow, `MEM_LAT=1`: `cause_req=3'b010` at t with `in_pc=0x108`.
  - t+1: `out_addr=0xFE`, `epc_we=1`, `epc_out=0x104`, `cause_code=1`.
  - t+2: `mem_rdata=0x12345AA7`.
  - t+3: `pc_load=1`, `pc_next=0xA7`.
  - t+4: `exc_busy=0`.
- Simultaneous causes: `cause_req=3'b101` → first sequence at `0xFD` (code 0), one IDLE cycle, then a second sequence at `0xFF` (code 2). Exactly two `pc_load` pulses.
- Cause during busy: `3'b100` arrives during LOAD of a code-1 sequence → latched; its VEC starts at `0xFF` after RET + IDLE.
- Reset mid-sequence: `reset` high in a VEC cycle (`MEM_LAT=3`) → next cycle all outputs 0, and no `pc_load` follows. A previously pending cause is not serviced.
- EPC wrap: `in_pc=0x2` with a cause → `epc_out=0xFFFFFFFE`.
